// File: rtl/hamming74_encoder_tx_if.sv
// Bus bundle for the serial Hamming(7,4) transmitter.
// Handshake: a nibble transfers on an enabled rising clk edge where
// data_valid=1 and data_ready=1. data_valid is ignored at any other time,
// and the producer may change data_in/inject_pos freely while ready is low.
interface hamming74_encoder_tx_if;
   logic [3:0] data_in;
   logic       data_valid;
   logic       data_ready;
   logic [2:0] inject_pos;
   logic       encode_out;
   logic       frame_start;
   logic       busy;
   logic [2:0] debug_counter_out;
   logic [1:0] debug_state_out;

   modport master (
      output data_in, data_valid, inject_pos,
      input  data_ready, encode_out, frame_start, busy,
             debug_counter_out, debug_state_out
   );

   modport slave (
      input  data_in, data_valid, inject_pos,
      output data_ready, encode_out, frame_start, busy,
             debug_counter_out, debug_state_out
   );
endinterface

// File: rtl/hamming74_encoder_tx.sv
// Hamming(7,4) encoder with serial LSB-first output. Each frame is 7
// codeword slots followed by one gap slot; a new nibble accepted in the
// gap slot gives back-to-back frames with an 8-cycle period.
module hamming74_encoder_tx (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         ena,
   hamming74_encoder_tx_if.slave        bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SEND = 2'd1,
      S_GAP  = 2'd2
   } state_t;

   state_t     r_state, w_state_nxt;
   logic [2:0] r_cnt, w_cnt_nxt;
   logic [6:0] r_shift, w_shift_nxt;
   logic       r_bit, w_bit_nxt;
   logic       r_fs, w_fs_nxt;
   logic [6:0] w_codeword;
   logic       w_ready;

   // Build the codeword {d3,d2,d1,c2,d0,c1,c0} and apply the optional bit flip
   always_comb begin
      w_codeword[0] = bus.data_in[0] ^ bus.data_in[1] ^ bus.data_in[3];
      w_codeword[1] = bus.data_in[0] ^ bus.data_in[2] ^ bus.data_in[3];
      w_codeword[2] = bus.data_in[0];
      w_codeword[3] = bus.data_in[1] ^ bus.data_in[2] ^ bus.data_in[3];
      w_codeword[4] = bus.data_in[1];
      w_codeword[5] = bus.data_in[2];
      w_codeword[6] = bus.data_in[3];
      if (bus.inject_pos != 3'd7) begin
         w_codeword[bus.inject_pos] = ~w_codeword[bus.inject_pos];
      end
   end

   // Ready in IDLE and GAP; forced low while reset is held
   assign w_ready = !rst && (r_state != S_SEND);

   // Next-state and next-output decode; defaults hold every register
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_shift_nxt = r_shift;
      w_bit_nxt   = r_bit;
      w_fs_nxt    = r_fs;
      case (r_state)
         S_IDLE, S_GAP: begin
            if (bus.data_valid) begin
               w_state_nxt = S_SEND;
               w_cnt_nxt   = 3'd0;
               w_shift_nxt = {1'b0, w_codeword[6:1]};
               w_bit_nxt   = w_codeword[0];
               w_fs_nxt    = 1'b1;
            end else if (r_state == S_GAP) begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = 3'd0;
               w_shift_nxt = 7'd0;
               w_bit_nxt   = 1'b0;
               w_fs_nxt    = 1'b0;
            end
         end
         S_SEND: begin
            w_fs_nxt = 1'b0;
            if (r_cnt == 3'd6) begin
               w_state_nxt = S_GAP;
               w_cnt_nxt   = 3'd7;
               w_bit_nxt   = 1'b0;
            end else begin
               w_cnt_nxt   = r_cnt + 3'd1;
               w_bit_nxt   = r_shift[0];
               w_shift_nxt = {1'b0, r_shift[6:1]};
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 3'd0;
            w_shift_nxt = 7'd0;
            w_bit_nxt   = 1'b0;
            w_fs_nxt    = 1'b0;
         end
      endcase
   end

   // State register: async clear, advance only on enabled edges
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= 3'd0;
         r_shift <= 7'd0;
         r_bit   <= 1'b0;
         r_fs    <= 1'b0;
      end else if (ena) begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_shift <= w_shift_nxt;
         r_bit   <= w_bit_nxt;
         r_fs    <= w_fs_nxt;
      end
   end

   assign bus.data_ready        = w_ready;
   assign bus.encode_out        = r_bit;
   assign bus.frame_start       = r_fs;
   assign bus.busy              = (r_state != S_IDLE);
   assign bus.debug_counter_out = r_cnt;
   assign bus.debug_state_out   = r_state;

endmodule

// File: tb/tb_hamming74_encoder_tx.sv
// Bench for hamming74_encoder_tx: frame-slot reference model plus
// directed frames with hand-computed bit sequences and random traffic.
module tb_hamming74_encoder_tx;
  logic clk = 1'b0;
  logic rst;
  logic ena;
  int   cmp_n = 0;
  int   err_n = 0;

  hamming74_encoder_tx_if bus();

  hamming74_encoder_tx dut (
    .clk (clk),
    .rst (rst),
    .ena (ena),
    .bus (bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_n++;
    if (act !== exp) begin
      err_n++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Hamming code by position: positions 1..7 map to b0..b6, parity bits
  // sit at power-of-two positions and cover every position sharing that bit.
  function automatic logic [6:0] enc(input logic [3:0] d, input logic [2:0] inj);
    logic [6:0] cw;
    int         di;
    cw = 7'd0;
    di = 0;
    for (int p = 1; p <= 7; p++) begin
      if ((p & (p - 1)) != 0) begin
        cw[p-1] = d[di];
        di++;
      end
    end
    for (int pp = 1; pp <= 4; pp = pp * 2) begin
      for (int q = 1; q <= 7; q++) begin
        if (q != pp && (q & pp) != 0) cw[pp-1] = cw[pp-1] ^ cw[q-1];
      end
    end
    if (inj != 3'd7) cw = cw ^ (7'd1 << inj);
    return cw;
  endfunction

  // reference model: slot index within the frame, -1 when idle
  int         m_pos = -1;
  logic [6:0] m_cw  = 7'd0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pos = -1;
    end else if (ena) begin
      if ((m_pos < 0 || m_pos == 7) && bus.data_valid) begin
        m_cw  = enc(bus.data_in, bus.inject_pos);
        m_pos = 0;
      end else if (m_pos >= 0 && m_pos < 7) begin
        m_pos = m_pos + 1;
      end else begin
        m_pos = -1;
      end
    end
  end

  // compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    logic exp_bit;
    exp_bit = (m_pos >= 0 && m_pos <= 6) ? m_cw[m_pos] : 1'b0;
    check("encode_out", bus.encode_out, exp_bit);
    check("frame_start", bus.frame_start, (m_pos == 0));
    check("busy", bus.busy, (m_pos >= 0));
    check("counter", bus.debug_counter_out, (m_pos < 0) ? 0 : m_pos);
    check("data_ready", bus.data_ready, !rst && !(m_pos >= 0 && m_pos <= 6));
  end

  // driver tasks
  task automatic start(input logic [3:0] d, input logic [2:0] inj);
    @(negedge clk);
    bus.data_in    = d;
    bus.inject_pos = inj;
    bus.data_valid = 1'b1;
    @(posedge clk);
    #1 bus.data_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [15:0] bits;
  logic [15:0] fs;

  initial begin
    rst            = 1'b1;
    ena            = 1'b1;
    bus.data_in    = 4'd0;
    bus.data_valid = 1'b0;
    bus.inject_pos = 3'd7;

    // model pins
    check("enc_1011", enc(4'b1011, 3'd7), 7'b1010101);
    check("enc_0001", enc(4'b0001, 3'd7), 7'b0000111);
    check("enc_1111", enc(4'b1111, 3'd7), 7'b1111111);
    check("enc_0000_inj3", enc(4'b0000, 3'd3), 7'b0001000);

    #2;
    check("rst_ready", bus.data_ready, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_enc", bus.encode_out, 1'b0);
    check("rst_cnt", bus.debug_counter_out, 3'd0);
    idle(2);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", bus.data_ready, 1'b1);

    // basic frame right after reset release
    start(4'b1011, 3'd7);
    bits = 0; fs = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bits[i] = bus.encode_out;
      fs[i]   = bus.frame_start;
    end
    check("f1011_bits", bits, 16'h0055);
    check("f1011_fs", fs, 16'h0001);
    idle(2);

    // back-to-back frames with valid held high
    @(negedge clk);
    bus.data_in = 4'b0001; bus.inject_pos = 3'd7; bus.data_valid = 1'b1;
    @(posedge clk);
    #1 bus.data_in = 4'b1111;
    bits = 0; fs = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bits[i] = bus.encode_out;
      fs[i]   = bus.frame_start;
      if (i == 8) bus.data_valid = 1'b0;
    end
    check("b2b_bits", bits, 16'h7F07);
    check("b2b_fs", fs, 16'h0101);
    idle(2);

    // injected error on bit 3
    start(4'b0000, 3'd3);
    bits = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bits[i] = bus.encode_out;
    end
    check("inj3_bits", bits, 16'h0008);
    idle(2);

    // clock enable low for 3 cycles at counter 4
    start(4'b1011, 3'd7);
    bits = 0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      bits[i] = bus.encode_out;
      if (i == 4) begin
        check("ena_cnt4", bus.debug_counter_out, 3'd4);
        ena = 1'b0;
      end
      if (i == 7) ena = 1'b1;
    end
    check("ena_bits", bits, 16'h02F5);
    idle(2);

    // reset at counter 3 aborts the frame
    start(4'b1000, 3'd7);
    for (int i = 0; i < 4; i++) @(negedge clk);
    check("abort_cnt3", bus.debug_counter_out, 3'd3);
    check("abort_b3", bus.encode_out, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("abort_enc", bus.encode_out, 1'b0);
    check("abort_busy", bus.busy, 1'b0);
    check("abort_ready", bus.data_ready, 1'b0);
    check("abort_cnt", bus.debug_counter_out, 3'd0);
    idle(2);
    rst = 1'b0;
    start(4'b1011, 3'd7);
    bits = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bits[i] = bus.encode_out;
    end
    check("post_rst_bits", bits, 16'h0055);
    idle(2);

    // valid pulsed during SEND is ignored
    start(4'b0001, 3'd7);
    bits = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      bits[i] = bus.encode_out;
      if (i == 2) begin
        bus.data_in = 4'b1111; bus.inject_pos = 3'd7; bus.data_valid = 1'b1;
      end
      if (i == 3) bus.data_valid = 1'b0;
    end
    check("ignore_bits", bits, 16'h0007);
    check("ignore_idle_busy", bus.busy, 1'b0);
    check("ignore_idle_cnt", bus.debug_counter_out, 3'd0);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      @(posedge clk);
      #1;
      ena            = ($urandom_range(0, 9) != 0);
      bus.data_valid = ($urandom_range(0, 2) != 0);
      bus.data_in    = 4'($urandom_range(0, 15));
      bus.inject_pos = 3'($urandom_range(0, 7));
      rst            = ($urandom_range(0, 79) == 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0; ena = 1'b1; bus.data_valid = 1'b0;
    idle(12);
    check("final_busy", bus.busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end
endmodule

// File: doc/hamming74_encoder_tx.md
HAMMING74_ENCODER_TX -- requirements
Module: hamming74_encoder_tx

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock; all state on rising edge.
REQ-002 SHALL have ports: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: ena  in  1  clock enable; low freezes all state and outputs.
REQ-004 SHALL have ports: data_in  in  4  nibble to encode {d3,d2,d1,d0}.
REQ-005 SHALL have ports: data_valid  in  1  data_in offered this cycle.
REQ-006 SHALL have ports: data_ready  out  1  block can accept a nibble this cycle.
REQ-007 SHALL have ports: inject_pos  in  3  sampled with data_in; 0..6 flips that codeword bit, 7 means no error injected.
REQ-008 SHALL have ports: encode_out  out  1  serial codeword bit, registered.
REQ-009 SHALL have ports: frame_start  out  1  high during the cycle encode_out carries bit 0.
REQ-010 SHALL have ports: busy  out  1  high while a frame (bits plus gap slot) is in progress.
REQ-011 SHALL have ports: debug_counter_out  out  3  current slot counter.

Function
REQ-012 Codeword bit map SHALL be: b0=c0, b1=c1, b2=d0, b3=c2, b4=d1, b5=d2, b6=d3.
REQ-013 Parity SHALL be even: c0=d0^d1^d3; c1=d0^d2^d3; c2=d1^d2^d3.
REQ-014 Injected error SHALL invert exactly bit inject_pos after parity generation; inject_pos=7 leaves the codeword unchanged.
REQ-015 Frame SHALL be 8 slots: slots 0..6 carry b0..b6, LSB first; slot 7 is a gap with encode_out=0.
REQ-016 States SHALL be IDLE, SEND, GAP.
REQ-017 In IDLE, data_ready SHALL be 1; encode_out=0; busy=0; counter=0.
REQ-018 Handshake SHALL be: transfer occurs on an enabled rising edge with data_valid=1 and data_ready=1.
REQ-019 On transfer from IDLE or GAP: codeword loaded into 7-bit shift register; state→SEND; counter→0; encode_out→b0; frame_start→1 for that cycle only.
REQ-020 In SEND: data_ready=0; busy=1; each enabled edge increments counter and drives next bit.
REQ-021 After the edge presenting b6 (counter=6), the next enabled edge SHALL go to GAP (counter=7, encode_out=0).
REQ-022 In GAP: busy=1, data_ready=1.
REQ-023 In GAP, a transfer at the next enabled edge SHALL start a new frame (REQ-019), giving back-to-back frames with a period of exactly 8 cycles.
REQ-024 In GAP with no transfer at the next enabled edge, the block SHALL return to IDLE.
REQ-025 Latency SHALL be: b0 visible on encode_out 1 cycle after the accepting edge; bit k visible k+1 cycles after it.
REQ-026 data_valid while data_ready=0 SHALL be ignored; it SHALL NOT be queued or corrupt the current frame.
REQ-027 With ena=0: state, counter, shift register and all outputs SHALL hold; no transfer SHALL occur regardless of data_valid.
REQ-028 Counter SHALL wrap 7→0 only via a new frame start; it SHALL never exceed 7.

Reset
REQ-029 rst=1 SHALL immediately, without a clock, force: IDLE, counter=0, shift register=0, encode_out=0, frame_start=0, busy=0.
REQ-030 data_ready SHALL be 1 while rst=0 in IDLE, and 0 while rst=1.
REQ-031 Reset asserted mid-frame SHALL abort the frame; no remaining bits SHALL be emitted.
REQ-032 The first enabled edge after reset release SHALL be able to accept a nibble.

Verification
REQ-033 data_in=4'b1011, inject_pos=7, ena=1 -> encode_out over slots 0..7 = 1,0,1,0,1,0,1,0; frame_start only in slot 0.
REQ-034 data_in=4'b0001 then 4'b1111 held valid continuously -> slots 0..6 = 1,1,1,0,0,0,0; gap 0; then 1,1,1,1,1,1,1; second frame_start exactly 8 cycles after the first.
REQ-035 data_in=4'b0000, inject_pos=3 -> bits 0,0,0,1,0,0,0.
REQ-036 Toggle ena low for 3 cycles mid-frame at counter=4 -> encode_out holds b4 for 4 cycles total; the remaining sequence is intact.
REQ-037 Assert rst at counter=3 -> outputs immediately 0 and busy=0; after release, data_in=4'b1011 produces a full, correct frame.
REQ-038 data_valid pulsed during SEND with different data -> ignored; the current frame is unchanged and the block returns to IDLE after the gap.
